// File: rtl/mc_rv_core.sv
// Multi-cycle RV32I/RV64I integer core: FETCH/DECODE/EXEC/WB sequencer with an
// OP, OP-IMM and LUI datapath, ALU flags, debug view and sticky illegal halt.
module mc_rv_core #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     NREG     = 32,
   parameter logic [XLEN-1:0] PC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [31:0]     imem_rdata,
   input  logic [2:0]      dbg_sel,
   output logic [XLEN-1:0] dbg_data,
   output logic [3:0]      flags,
   output logic            retire,
   output logic            illegal,
   output logic [2:0]      state
);

   localparam int unsigned RW = $clog2(NREG);
   localparam int unsigned SW = $clog2(XLEN);

   localparam logic [6:0] OPC_OP  = 7'b0110011;
   localparam logic [6:0] OPC_OPI = 7'b0010011;
   localparam logic [6:0] OPC_LUI = 7'b0110111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t          st;
   logic [XLEN-1:0] pc, a, b, f, retire_cnt;
   logic [31:0]     ir;
   logic [XLEN-1:0] regs [NREG];

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [4:0] rd, rs1, rs2;
   logic       is_op, is_opi, is_lui;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign funct7 = ir[31:25];
   assign is_op  = (opcode == OPC_OP);
   assign is_opi = (opcode == OPC_OPI);
   assign is_lui = (opcode == OPC_LUI);

   // Encoding legality, including register indices beyond a 16-entry file
   logic legal, shift_ok, idx_bad;
   always_comb begin
      legal    = 1'b0;
      shift_ok = (ir[31] == 1'b0) && (ir[29:26] == 4'd0) && ((XLEN == 64) || (ir[25] == 1'b0));
      idx_bad  = (NREG < 32) && ((ir[11] && (is_op || is_opi || is_lui)) ||
                                 (ir[19] && (is_op || is_opi)) ||
                                 (ir[24] && is_op));
      if (is_op) begin
         legal = (funct7 == 7'h00) ||
                 ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
      end else if (is_opi) begin
         case (funct3)
            3'd1:    legal = shift_ok && (ir[30] == 1'b0);
            3'd5:    legal = shift_ok;
            default: legal = 1'b1;
         endcase
      end else if (is_lui) begin
         legal = 1'b1;
      end
      if (idx_bad) legal = 1'b0;
   end

   logic signed [11:0] imm_i;
   logic signed [31:0] imm_u;
   logic [XLEN-1:0]    imm, op2;
   assign imm_i = ir[31:20];
   assign imm_u = {ir[31:12], 12'h000};
   assign imm   = is_lui ? XLEN'(imm_u) : XLEN'(imm_i);
   assign op2   = is_op ? b : imm;

   // ALU result and flag generation
   logic [XLEN:0]   sum, diff;
   logic [SW-1:0]   shamt;
   logic [XLEN-1:0] alu_res;
   logic            zf, cf, of, sf;
   always_comb begin
      sum   = {1'b0, a} + {1'b0, op2};
      diff  = {1'b0, a} - {1'b0, op2};
      shamt = op2[SW-1:0];
      case (funct3)
         3'd0:    alu_res = (is_op && ir[30]) ? diff[XLEN-1:0] : sum[XLEN-1:0];
         3'd1:    alu_res = a << shamt;
         3'd2:    alu_res = XLEN'($signed(a) < $signed(op2));
         3'd3:    alu_res = XLEN'(a < op2);
         3'd4:    alu_res = a ^ op2;
         3'd5:    alu_res = ir[30] ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
         3'd6:    alu_res = a | op2;
         default: alu_res = a & op2;
      endcase
      zf = (alu_res == '0);
      sf = alu_res[XLEN-1];
      cf = 1'b0;
      of = 1'b0;
      if (funct3 == 3'd0) begin
         if (is_op && ir[30]) begin
            cf = diff[XLEN];
            of = (a[XLEN-1] != op2[XLEN-1]) && (alu_res[XLEN-1] != a[XLEN-1]);
         end else begin
            cf = sum[XLEN];
            of = (a[XLEN-1] == op2[XLEN-1]) && (alu_res[XLEN-1] != a[XLEN-1]);
         end
      end
   end

   logic [XLEN-1:0] w_data, rd_a, rd_b;
   assign w_data = is_lui ? imm : f;
   assign rd_a   = (rs1 == 5'd0) ? '0 : regs[rs1[RW-1:0]];
   assign rd_b   = (rs2 == 5'd0) ? '0 : regs[rs2[RW-1:0]];

   // Sequencer and architectural state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st         <= S_FETCH;
         pc         <= PC_RESET;
         ir         <= '0;
         a          <= '0;
         b          <= '0;
         f          <= '0;
         flags      <= '0;
         retire_cnt <= '0;
         illegal    <= 1'b0;
         retire     <= 1'b0;
         imem_req   <= 1'b1;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         retire <= 1'b0;
         case (st)
            S_FETCH: begin
               if (imem_valid) begin
                  ir       <= imem_rdata;
                  pc       <= pc + XLEN'(4);
                  imem_req <= 1'b0;
                  st       <= S_DECODE;
               end
            end
            S_DECODE: begin
               a <= rd_a;
               b <= rd_b;
               if (legal) begin
                  st <= S_EXEC;
               end else begin
                  illegal <= 1'b1;
                  st      <= S_HALT;
               end
            end
            S_EXEC: begin
               f <= alu_res;
               if (!is_lui) flags <= {zf, cf, of, sf};
               retire <= 1'b1;
               st     <= S_WB;
            end
            S_WB: begin
               if (rd != 5'd0) regs[rd[RW-1:0]] <= w_data;
               retire_cnt <= retire_cnt + XLEN'(1);
               imem_req   <= 1'b1;
               st         <= S_FETCH;
            end
            S_HALT:  st <= S_HALT;
            default: st <= S_HALT;
         endcase
      end
   end

   assign imem_addr = pc;
   assign state     = st;

   always_comb begin
      case (dbg_sel)
         3'd0:    dbg_data = pc;
         3'd1:    dbg_data = XLEN'(ir);
         3'd2:    dbg_data = w_data;
         3'd3:    dbg_data = a;
         3'd4:    dbg_data = b;
         3'd5:    dbg_data = f;
         3'd6:    dbg_data = XLEN'(flags);
         default: dbg_data = retire_cnt;
      endcase
   end

endmodule

// File: tb/tb_mc_rv_core.sv
// Self-checking bench for mc_rv_core: directed scenarios plus random OP/OP-IMM/LUI
// instructions checked against an instruction-level reference model.
module tb_mc_rv_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [2:0]  dbg_sel = 3'd0;
   logic        imem_req, retire, illegal;
   logic [31:0] imem_addr, dbg_data;
   logic [3:0]  flags;
   logic [2:0]  state;

   mc_rv_core dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_rdata (imem_rdata),
      .dbg_sel    (dbg_sel),
      .dbg_data   (dbg_data),
      .flags      (flags),
      .retire     (retire),
      .illegal    (illegal),
      .state      (state)
   );

   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Architectural model
   logic [31:0] mregs [32];
   logic [31:0] mpc, mcnt;
   logic [3:0]  mflags;

   typedef enum int {M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA,
                     M_OR, M_AND, M_LUI, M_ILL} op_e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic read_dbg(input logic [2:0] sel, output logic [31:0] v);
      dbg_sel = sel;
      #1;
      v = dbg_data;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      mpc    = 32'h0;
      mcnt   = 32'h0;
      mflags = 4'h0;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      imem_valid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      model_reset();
   endtask

   function automatic op_e classify(input logic [31:0] ins);
      logic [6:0] f7;
      logic [2:0] f3;
      f7 = ins[31:25];
      f3 = ins[14:12];
      if (ins[6:0] == 7'h33) begin
         if (f7 == 7'h00) begin
            case (f3)
               3'd0: return M_ADD;  3'd1: return M_SLL;
               3'd2: return M_SLT;  3'd3: return M_SLTU;
               3'd4: return M_XOR;  3'd5: return M_SRL;
               3'd6: return M_OR;   default: return M_AND;
            endcase
         end
         if (f7 == 7'h20 && f3 == 3'd0) return M_SUB;
         if (f7 == 7'h20 && f3 == 3'd5) return M_SRA;
         return M_ILL;
      end
      if (ins[6:0] == 7'h13) begin
         case (f3)
            3'd0: return M_ADD;
            3'd1: return (f7 == 7'h00) ? M_SLL : M_ILL;
            3'd2: return M_SLT;
            3'd3: return M_SLTU;
            3'd4: return M_XOR;
            3'd5: return (f7 == 7'h00) ? M_SRL : ((f7 == 7'h20) ? M_SRA : M_ILL);
            3'd6: return M_OR;
            default: return M_AND;
         endcase
      end
      if (ins[6:0] == 7'h37) return M_LUI;
      return M_ILL;
   endfunction

   // Run one instruction through the core with a given number of fetch stalls
   task automatic exec_instr(input logic [31:0] ins, input int stalls);
      op_e         op;
      logic [31:0] x, yreg, y, r, wd, v;
      longint      ls;
      logic [32:0] usum;
      bit          cf, of;
      int          last, exp_st;
      op   = classify(ins);
      x    = mregs[ins[19:15]];
      yreg = mregs[ins[24:20]];
      y    = (ins[6:0] == 7'h33) ? yreg : {{20{ins[31]}}, ins[31:20]};
      cf   = 1'b0;
      of   = 1'b0;
      r    = 32'h0;
      case (op)
         M_ADD: begin
            r    = x + y;
            usum = {1'b0, x} + {1'b0, y};
            cf   = usum[32];
            ls   = longint'($signed(x)) + longint'($signed(y));
            of   = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
         end
         M_SUB: begin
            r  = x - y;
            cf = (x < y);
            ls = longint'($signed(x)) - longint'($signed(y));
            of = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
         end
         M_SLL:  r = x << y[4:0];
         M_SRL:  r = x >> y[4:0];
         M_SRA:  r = $signed(x) >>> y[4:0];
         M_SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         M_SLTU: r = (x < y) ? 32'd1 : 32'd0;
         M_XOR:  r = x ^ y;
         M_OR:   r = x | y;
         M_AND:  r = x & y;
         default: r = 32'h0;
      endcase
      wd   = (op == M_LUI) ? {ins[31:12], 12'h000} : r;
      last = (op == M_ILL) ? stalls + 2 : stalls + 4;

      for (int c = 1; c <= last; c++) begin
         if (c <= stalls) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
         end else if (c == stalls + 1) begin
            imem_valid = 1'b1;
            imem_rdata = ins;
         end else begin
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
         end
         if (c <= stalls + 1) begin
            chk("fetch_req", 32'(imem_req), 32'd1);
            chk("fetch_addr", imem_addr, mpc);
         end
         exp_st = (c <= stalls + 1) ? 0 : c - stalls - 1;
         chk("state_seq", 32'(state), 32'(exp_st));
         chk("retire_cycle", 32'(retire), 32'(c == stalls + 4));
         step();
      end
      imem_valid = 1'b0;
      mpc = mpc + 32'd4;

      if (op == M_ILL) begin
         chk("halt_state", 32'(state), 32'd4);
         chk("halt_illegal", 32'(illegal), 32'd1);
         chk("halt_req", 32'(imem_req), 32'd0);
         chk("halt_addr", imem_addr, mpc);
         return;
      end

      if (ins[11:7] != 5'd0) mregs[ins[11:7]] = wd;
      mcnt = mcnt + 32'd1;
      if (op != M_LUI) mflags = {(r == 32'h0), cf, of, r[31]};

      chk("wb_state", 32'(state), 32'd0);
      chk("wb_retire_low", 32'(retire), 32'd0);
      chk("wb_req", 32'(imem_req), 32'd1);
      chk("flags_out", 32'(flags), 32'(mflags));
      read_dbg(3'd0, v); chk("dbg_pc", v, mpc);
      read_dbg(3'd1, v); chk("dbg_ir", v, ins);
      read_dbg(3'd2, v); chk("dbg_wdata", v, wd);
      read_dbg(3'd3, v); chk("dbg_a", v, x);
      read_dbg(3'd4, v); chk("dbg_b", v, yreg);
      if (op != M_LUI) begin
         read_dbg(3'd5, v); chk("dbg_f", v, r);
      end
      read_dbg(3'd6, v); chk("dbg_flags", v, 32'(mflags));
      read_dbg(3'd7, v); chk("dbg_retire_cnt", v, mcnt);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [11:0] imm;
      int          k;
      k   = $urandom_range(0, 9);
      rd  = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      f3  = 3'($urandom_range(0, 7));
      imm = 12'($urandom);
      if (k <= 3) begin
         return {((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                 rs2, rs1, f3, rd, 7'h33};
      end
      if (k <= 7) begin
         if (f3 == 3'd1) imm[11:5] = 7'h00;
         if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         return {imm, rs1, f3, rd, 7'h13};
      end
      return {20'($urandom), rd, 7'h37};
   endfunction

   initial begin
      logic [31:0] v;

      // Reset state
      do_reset();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd1);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_flags", 32'(flags), 32'h0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      read_dbg(3'd7, v); chk("rst_retire_cnt", v, 32'h0);
      read_dbg(3'd1, v); chk("rst_ir", v, 32'h0);

      // ADDI then ADD, back to back
      exec_instr(32'h00500093, 0);
      exec_instr(32'h00108133, 0);
      read_dbg(3'd5, v); chk("add_result_10", v, 32'd10);

      // LUI / ADDI / SUB signed overflow
      exec_instr(32'h800000B7, 0);
      exec_instr(32'h00100113, 0);
      exec_instr(32'h402081B3, 0);
      read_dbg(3'd5, v); chk("sub_f", v, 32'h7FFFFFFF);
      chk("sub_flags", 32'(flags), 32'(4'b0010));

      // Fetch wait states
      exec_instr(32'h00300213, 3);

      // Random instruction stream
      for (int i = 0; i < 60; i++) exec_instr(rand_instr(), $urandom_range(0, 2));

      // Illegal instruction halts until reset
      do_reset();
      exec_instr(32'h00500093, 0);
      exec_instr(32'h00000073, 1);
      for (int i = 0; i < 12; i++) begin
         imem_valid = 1'($urandom_range(0, 1));
         imem_rdata = 32'h00100093;
         step();
         chk("halt_hold_state", 32'(state), 32'd4);
         chk("halt_hold_req", 32'(imem_req), 32'd0);
         chk("halt_hold_retire", 32'(retire), 32'd0);
      end
      imem_valid = 1'b0;
      chk("halt_hold_pc", imem_addr, mpc);
      read_dbg(3'd7, v); chk("halt_hold_cnt", v, mcnt);

      // Unsupported funct7 (MUL) is illegal
      do_reset();
      exec_instr(32'h02208033, 0);

      // Writes to x0 are discarded
      do_reset();
      exec_instr(32'h00700013, 0);
      exec_instr(32'h000002B3, 0);
      read_dbg(3'd3, v); chk("x0_reads_zero", v, 32'h0);

      // Reset during EXEC: no retire, no write
      do_reset();
      exec_instr(32'h00900113, 0);
      imem_valid = 1'b1;
      imem_rdata = 32'h00500093;
      step();
      imem_valid = 1'b0;
      step();
      chk("mid_exec_state", 32'(state), 32'd2);
      rst_n = 1'b0;
      step();
      chk("exec_rst_retire", 32'(retire), 32'd0);
      chk("exec_rst_state", 32'(state), 32'd0);
      rst_n = 1'b1;
      model_reset();
      read_dbg(3'd0, v); chk("exec_rst_pc", v, 32'h0);
      exec_instr(32'h000081B3, 0);
      read_dbg(3'd3, v); chk("exec_rst_x1", v, 32'h0);

      // Reset during WB: no register write
      imem_valid = 1'b1;
      imem_rdata = 32'h00500093;
      step();
      imem_valid = 1'b0;
      step();
      step();
      chk("mid_wb_state", 32'(state), 32'd3);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      model_reset();
      read_dbg(3'd7, v); chk("wb_rst_cnt", v, 32'h0);
      exec_instr(32'h000081B3, 0);
      read_dbg(3'd3, v); chk("wb_rst_x1", v, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
